// File: rtl/serial_pkg.sv
//------------------------------------------------------------------------------
// serial_pkg : state encodings and default constants for the UART port
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_RX_DEPTH     = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/serial_rx_fifo.sv
//------------------------------------------------------------------------------
// serial_rx_fifo : first-word-fall-through receive FIFO, head reads 0 when empty
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_rx_fifo
  import serial_pkg::*;
#(
  parameter int RX_DEPTH = DEF_RX_DEPTH
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       full_o
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(RX_DEPTH);

  logic [7:0]       mem_q [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == C_FULL);
  assign do_pop  = pop_i && valid_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : 8'h00;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/serial_uart_port.sv
//------------------------------------------------------------------------------
// serial_uart_port : 8N1 UART transmitter and receiver with receive FIFO
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_uart_port
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int RX_DEPTH     = DEF_RX_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_wren_in,
  input  logic [7:0] s_data_in,
  output logic       s_data_ready_out,
  input  logic       s_rden_in,
  output logic [7:0] s_data_out,
  output logic       s_data_valid_out,
  input  logic       uart_rxd_in,
  output logic       uart_txd_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             txd_q, txd_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_meta_q, rx_sync_q;
  logic             rx_push;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             fifo_full;

  assign s_data_ready_out = (tx_state_q == TX_IDLE);
  assign uart_txd_out     = txd_q;
  assign rx_overrun_out   = overrun_q;
  assign rx_frame_err_out = frame_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // txd_d is the level for the next bit period, so the line is fully registered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (s_wren_in) begin
          tx_state_d = TX_START;
          tx_shift_d = s_data_in;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= uart_rxd_in;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end
      end
      RX_START: begin
        // Mid-start resample; a high line here was only a glitch.
        if (rx_cnt_q == C_HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == C_BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == C_BIT_LAST) begin
          rx_cnt_d    = '0;
          rx_state_d  = RX_IDLE;
          rx_push     = rx_sync_q;
          frame_err_d = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    overrun_d = rx_push && fifo_full && !(s_rden_in && s_data_valid_out);
  end

  serial_rx_fifo #(
    .RX_DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clock_i (clock),
    .reset_i (reset),
    .push_i  (rx_push),
    .data_i  (rx_shift_q),
    .pop_i   (s_rden_in),
    .data_o  (s_data_out),
    .valid_o (s_data_valid_out),
    .full_o  (fifo_full)
  );

endmodule

`default_nettype wire
